sha512_session_arbiter: RTL and testbench

// - Shares the single SHA-512 engine (sha512_litex wrapper) between NUM_REQ requesters (CPU CSR path, DMA, ...) on whole-hash sessions.
// - A grant covers one complete hash: start, message writes, process, digest readout.
// - Sequences sha_en, hash_start, hash_process and the msg FIFO port, so no two sessions interleave in the engine.

---
 rtl/sha512_session_arbiter_pkg.sv | 16 +
 rtl/sha512_session_arbiter_if.sv | 27 ++
 rtl/sha512_arb_rr_pick.sv | 42 ++++
 rtl/sha512_session_arbiter.sv | 163 ++++++++++++++++
 tb/tb_sha512_session_arbiter.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sha512_session_arbiter_pkg.sv
// Shared types and limits for the SHA-512 session arbiter.
// Combinational only; no latency and no backpressure.
package sha512_session_arbiter_pkg;

  localparam int SHA_ARB_MAX_REQ = 8;
  localparam int SHA_ARB_WD_W    = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GRANTED = 3'd1,
    ST_ACTIVE  = 3'd2,
    ST_DIGEST  = 3'd3,
    ST_HOLD    = 3'd4
  } arb_state_e;

endpackage

// File: rtl/sha512_session_arbiter_if.sv
// Engine-side bus between the session arbiter (master) and the SHA-512 engine (slave).
// No latency or backpressure of its own; the engine paces writes with sha_fifo_gnt.
interface sha512_session_arbiter_if;

  logic        sha_en;
  logic        sha_hash_start;
  logic        sha_hash_process;
  logic        sha_fifo_req;
  logic        sha_fifo_we;
  logic [63:0] sha_fifo_wdata;
  logic [7:0]  sha_fifo_wmask;
  logic        sha_fifo_gnt;
  logic        sha_hash_done;

  modport master (
    output sha_en, sha_hash_start, sha_hash_process,
    output sha_fifo_req, sha_fifo_we, sha_fifo_wdata, sha_fifo_wmask,
    input  sha_fifo_gnt, sha_hash_done
  );

  modport slave (
    input  sha_en, sha_hash_start, sha_hash_process,
    input  sha_fifo_req, sha_fifo_we, sha_fifo_wdata, sha_fifo_wmask,
    output sha_fifo_gnt, sha_hash_done
  );

endinterface

// File: rtl/sha512_arb_rr_pick.sv
// Round-robin picker: first set request at or after i_ptr, wrapping; one-hot plus index.
// Purely combinational, zero latency; no backpressure.
module sha512_arb_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_vld
);

  logic [NUM_REQ-1:0] w_rot;

  assign w_rot = NUM_REQ'({i_req, i_req} >> i_ptr);

  // Scan high to low so the lowest rotated position (closest to i_ptr) wins.
  always_comb begin
    logic [IDX_W:0] s;
    s     = '0;
    o_idx = '0;
    o_vld = |i_req;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        s = {1'b0, i_ptr} + (IDX_W+1)'(i);
        if (s >= (IDX_W+1)'(NUM_REQ)) begin
          s = s - (IDX_W+1)'(NUM_REQ);
        end
        o_idx = s[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    o_gnt = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      o_gnt[j] = o_vld && (o_idx == IDX_W'(j));
    end
  end

endmodule

// File: rtl/sha512_session_arbiter.sv
// Grants the SHA-512 engine to one requester per whole hash session; grant 1 cycle after req.
// Writes are paced by the engine's fifo_gnt; optional idle watchdog under SHA512_ARB_WATCHDOG_EN.
module sha512_session_arbiter
  import sha512_session_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [NUM_REQ-1:0]   hash_start_i,
  input  logic [NUM_REQ-1:0]   hash_process_i,
  input  logic [NUM_REQ-1:0]   fifo_req_i,
  input  logic [NUM_REQ-1:0]   fifo_we_i,
  input  logic [NUM_REQ*64-1:0] fifo_wdata_i,
  input  logic [NUM_REQ*8-1:0] fifo_wmask_i,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic [NUM_REQ-1:0]   fifo_gnt_o,
  output logic [NUM_REQ-1:0]   done_o,
  output logic [NUM_REQ-1:0]   abort_o,
  sha512_session_arbiter_if.master sha_bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e         r_state;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   r_owner;
  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] r_done;
  logic [NUM_REQ-1:0] r_abort;
  logic               r_sha_en;

  logic [NUM_REQ-1:0] w_pick_gnt;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_pick_vld;
  logic [IDX_W-1:0]   w_next_ptr;
  logic               w_owner_req;
  logic               w_is_granted;
  logic               w_is_active;
  logic               w_wd_fire;
  logic               w_kill;
  logic [63:0]        w_wdata_arr [NUM_REQ];
  logic [7:0]         w_wmask_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign w_wdata_arr[g] = fifo_wdata_i[64*g +: 64];
    assign w_wmask_arr[g] = fifo_wmask_i[8*g +: 8];
  end

  sha512_arb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .i_req (req_i),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx),
    .o_vld (w_pick_vld)
  );

  assign w_owner_req  = req_i[r_owner];
  assign w_is_granted = (r_state == ST_GRANTED);
  assign w_is_active  = (r_state == ST_ACTIVE);
  assign w_next_ptr   = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + IDX_W'(1);
  assign w_kill       = !w_owner_req || w_wd_fire;

`ifdef SHA512_ARB_WATCHDOG_EN
  logic [SHA_ARB_WD_W-1:0] r_wd_cnt;
  logic                    w_wd_timed;
  logic                    w_wd_kick;

  assign w_wd_timed = w_is_granted || w_is_active;
  assign w_wd_kick  = hash_start_i[r_owner] || hash_process_i[r_owner] ||
                      (fifo_req_i[r_owner] && fifo_we_i[r_owner]);
  assign w_wd_fire  = w_wd_timed && !w_wd_kick &&
                      (r_wd_cnt == SHA_ARB_WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wd_cnt <= '0;
    end else if (!w_wd_timed || w_wd_kick) begin
      r_wd_cnt <= '0;
    end else begin
      r_wd_cnt <= r_wd_cnt + SHA_ARB_WD_W'(1);
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
  assign w_wd_fire        = 1'b0;
`endif

  // Ending a session always drops sha_en for at least the following IDLE cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_grant  <= '0;
      r_done   <= '0;
      r_abort  <= '0;
      r_sha_en <= 1'b0;
    end else begin
      r_done  <= '0;
      r_abort <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_pick_vld) begin
            r_state  <= ST_GRANTED;
            r_owner  <= w_pick_idx;
            r_grant  <= w_pick_gnt;
            r_sha_en <= 1'b1;
          end
        end
        ST_GRANTED, ST_ACTIVE, ST_DIGEST: begin
          if (w_kill) begin
            r_abort  <= r_grant;
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_sha_en <= 1'b0;
            r_rr_ptr <= w_next_ptr;
          end else if (w_is_granted && hash_start_i[r_owner]) begin
            r_state <= ST_ACTIVE;
          end else if (w_is_active && hash_process_i[r_owner]) begin
            r_state <= ST_DIGEST;
          end else if ((r_state == ST_DIGEST) && sha_bus.sha_hash_done) begin
            r_done  <= r_grant;
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!w_owner_req) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_sha_en <= 1'b0;
            r_rr_ptr <= w_next_ptr;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_grant  <= '0;
          r_sha_en <= 1'b0;
        end
      endcase
    end
  end

  assign grant_o = r_grant;
  assign done_o  = r_done;
  assign abort_o = r_abort;

  assign sha_bus.sha_en           = r_sha_en;
  assign sha_bus.sha_hash_start   = w_is_granted && hash_start_i[r_owner];
  assign sha_bus.sha_hash_process = w_is_active && hash_process_i[r_owner];
  assign sha_bus.sha_fifo_req     = w_is_active && fifo_req_i[r_owner];
  assign sha_bus.sha_fifo_we      = w_is_active && fifo_we_i[r_owner];
  assign sha_bus.sha_fifo_wdata   = w_is_active ? w_wdata_arr[r_owner] : '0;
  assign sha_bus.sha_fifo_wmask   = w_is_active ? w_wmask_arr[r_owner] : '0;
  assign fifo_gnt_o = w_is_active ? (r_grant & {NUM_REQ{sha_bus.sha_fifo_gnt}}) : '0;

endmodule

// File: tb/tb_sha512_session_arbiter.sv
// Directed sessions for the SHA-512 session arbiter; expected output events are queued with
// their due cycle and a negedge monitor pops and compares every event the DUT produces.
module tb_sha512_session_arbiter;

  localparam int N = 2;

  localparam int EV_GRANT = 0;
  localparam int EV_EN    = 1;
  localparam int EV_START = 2;
  localparam int EV_WR    = 3;
  localparam int EV_PROC  = 4;
  localparam int EV_DONE  = 5;
  localparam int EV_ABORT = 6;

  typedef struct {
    int          kind;
    logic [79:0] val;
    int          cyc;
  } exp_t;

  exp_t q[$];

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, hstart, hproc, freq, fwe;
  logic [N*64-1:0] fwdata;
  logic [N*8-1:0]  fwmask;
  logic [N-1:0]    grant, fgnt, done, abort;
  logic [N-1:0]    prev_grant = '0;
  logic            prev_en = 1'b0;
  logic [63:0]     wv [4];
  logic [7:0]      wm [4];
  int              cyc = 0;
  int              n_vec = 0;
  int              n_err = 0;

  sha512_session_arbiter_if bus();

  sha512_session_arbiter #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_i          (req),
    .hash_start_i   (hstart),
    .hash_process_i (hproc),
    .fifo_req_i     (freq),
    .fifo_we_i      (fwe),
    .fifo_wdata_i   (fwdata),
    .fifo_wmask_i   (fwmask),
    .grant_o        (grant),
    .fifo_gnt_o     (fgnt),
    .done_o         (done),
    .abort_o        (abort),
    .sha_bus        (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    hstart = '0; hproc = '0; freq = '0; fwe = '0; fwdata = '0; fwmask = '0;
    bus.sha_fifo_gnt = 1'b0; bus.sha_hash_done = 1'b0;
  endtask

  task automatic expect_ev(input int kind, input logic [79:0] val, input int dly);
    exp_t e;
    e.kind = kind; e.val = val; e.cyc = cyc + dly;
    q.push_back(e);
  endtask

  function automatic logic [79:0] wr_val(input logic [1:0] g, input logic [7:0] m, input logic [63:0] d);
    return {4'b0, 1'b1, 1'b1, g, m, d};
  endfunction

  task automatic check_eq(input string name, input logic [79:0] got, input logic [79:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  task automatic observe(input int kind, input logic [79:0] val);
    exp_t e;
    n_vec++;
    if (q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event: got kind=%0d val=%h cyc=%0d required no event", kind, val, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.val !== val || e.cyc != cyc) begin
        n_err++;
        $display("FAIL event: got kind=%0d val=%h cyc=%0d required kind=%0d val=%h cyc=%0d",
                 kind, val, cyc, e.kind, e.val, e.cyc);
      end
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_grant"}, 80'(grant), 80'(0));
    check_eq({tag, "_fifo_gnt"}, 80'(fgnt), 80'(0));
    check_eq({tag, "_done_abort"}, 80'({done, abort}), 80'(0));
    check_eq({tag, "_sha_ctl"}, 80'({bus.sha_en, bus.sha_hash_start, bus.sha_hash_process,
                                     bus.sha_fifo_req, bus.sha_fifo_we}), 80'(0));
    check_eq({tag, "_sha_data"}, {8'h0, bus.sha_fifo_wmask, bus.sha_fifo_wdata}, 80'(0));
  endtask

  // Fixed kind order per cycle; stimulus pushes same-cycle events in this order.
  always @(negedge clk) begin
    if (grant !== prev_grant) begin
      observe(EV_GRANT, 80'(grant));
      prev_grant = grant;
    end
    if (bus.sha_en !== prev_en) begin
      observe(EV_EN, 80'(bus.sha_en));
      prev_en = bus.sha_en;
    end
    if (bus.sha_hash_start !== 1'b0) observe(EV_START, 80'(0));
    if (bus.sha_fifo_req !== 1'b0 || bus.sha_fifo_we !== 1'b0 || fgnt !== '0)
      observe(EV_WR, {4'b0, bus.sha_fifo_we, bus.sha_fifo_req, fgnt, bus.sha_fifo_wmask, bus.sha_fifo_wdata});
    if (bus.sha_hash_process !== 1'b0) observe(EV_PROC, 80'(0));
    if (done !== '0) observe(EV_DONE, 80'(done));
    if (abort !== '0) observe(EV_ABORT, 80'(abort));
  end

  initial begin
    wv[0] = 64'h0123_4567_89AB_CDEF; wm[0] = 8'hFF;
    wv[1] = 64'hDEAD_BEEF_CAFE_F00D; wm[1] = 8'h0F;
    wv[2] = 64'h0000_0000_0000_0001; wm[2] = 8'h80;
    wv[3] = 64'hFFFF_FFFF_FFFF_FFFF; wm[3] = 8'h01;
    rst = 1'b1; req = '0;
    idle_inputs();
    step(2);
    check_outputs_zero("reset");
    rst = 1'b0;
    step(2);

    // Both request from IDLE with rr_ptr 0: requester 0 first.
    req = 2'b11;
    expect_ev(EV_GRANT, 80'(2'b01), 1); expect_ev(EV_EN, 80'(1), 1);
    step(1);
    hstart = 2'b10; hproc = 2'b01;
    step(1); idle_inputs();
    hstart = 2'b01; expect_ev(EV_START, 80'(0), 0);
    step(1); idle_inputs();
    for (int i = 0; i < 3; i++) begin
      fwdata = {~wv[i], wv[i]}; fwmask = {~wm[i], wm[i]};
      freq = 2'b11; fwe = 2'b11; bus.sha_fifo_gnt = 1'b1;
      if (i == 0) hstart = 2'b10;
      expect_ev(EV_WR, wr_val(2'b01, wm[i], wv[i]), 0);
      step(1); idle_inputs();
    end
    fwdata = {64'h5555_5555_5555_5555, wv[3]}; fwmask = {8'h00, wm[3]};
    freq = 2'b01; fwe = 2'b01; bus.sha_fifo_gnt = 1'b1; hproc = 2'b01;
    expect_ev(EV_WR, wr_val(2'b01, wm[3], wv[3]), 0); expect_ev(EV_PROC, 80'(0), 0);
    step(1); idle_inputs();
    freq = 2'b01; fwe = 2'b01; fwdata = {64'h0, wv[0]}; fwmask = 16'h00FF;
    step(1); idle_inputs();
    bus.sha_hash_done = 1'b1; expect_ev(EV_DONE, 80'(2'b01), 1);
    step(1); idle_inputs();
    bus.sha_hash_done = 1'b1;
    step(1); idle_inputs();
    step(1);

    // Requester 0 releases in HOLD: one cycle with sha_en low, then requester 1.
    req = 2'b10;
    expect_ev(EV_GRANT, 80'(2'b00), 1); expect_ev(EV_EN, 80'(0), 1);
    expect_ev(EV_GRANT, 80'(2'b10), 2); expect_ev(EV_EN, 80'(1), 2);
    step(2);
    hstart = 2'b10; expect_ev(EV_START, 80'(0), 0);
    step(1); idle_inputs();
    req = 2'b11;
    for (int i = 0; i < 2; i++) begin
      fwdata = {wv[i+1], ~wv[i+1]}; fwmask = {wm[i+1], ~wm[i+1]};
      freq = 2'b11; fwe = 2'b11; bus.sha_fifo_gnt = 1'b1;
      expect_ev(EV_WR, wr_val(2'b10, wm[i+1], wv[i+1]), 0);
      step(1); idle_inputs();
    end

    // Owner 1 drops in ACTIVE: abort, then pending requester 0 after one IDLE cycle.
    req = 2'b01;
    expect_ev(EV_GRANT, 80'(2'b00), 1); expect_ev(EV_EN, 80'(0), 1); expect_ev(EV_ABORT, 80'(2'b10), 1);
    expect_ev(EV_GRANT, 80'(2'b01), 2); expect_ev(EV_EN, 80'(1), 2);
    step(2);

`ifdef SHA512_ARB_WATCHDOG_EN
    expect_ev(EV_GRANT, 80'(2'b00), 16); expect_ev(EV_EN, 80'(0), 16); expect_ev(EV_ABORT, 80'(2'b01), 16);
    expect_ev(EV_GRANT, 80'(2'b01), 17); expect_ev(EV_EN, 80'(1), 17);
    step(20);
`else
    step(1000);
`endif

    hstart = 2'b01; expect_ev(EV_START, 80'(0), 0);
    step(1); idle_inputs();
    fwdata = {64'h0, wv[1]}; fwmask = {8'h00, wm[1]};
    freq = 2'b01; fwe = 2'b01; bus.sha_fifo_gnt = 1'b1;
    expect_ev(EV_WR, wr_val(2'b01, wm[1], wv[1]), 0);
    step(1); idle_inputs();
    hproc = 2'b01; expect_ev(EV_PROC, 80'(0), 0);
    step(1); idle_inputs();

    // Reset while in DIGEST clears every output without waiting for a clock.
    expect_ev(EV_GRANT, 80'(2'b00), 0); expect_ev(EV_EN, 80'(0), 0);
    rst = 1'b1; req = '0;
    #1;
    check_outputs_zero("mid_reset");
    step(2);
    rst = 1'b0;
    step(1);

    req = 2'b10;
    expect_ev(EV_GRANT, 80'(2'b10), 1); expect_ev(EV_EN, 80'(1), 1);
    step(1);
    hstart = 2'b10; expect_ev(EV_START, 80'(0), 0);
    step(1); idle_inputs();
    fwdata = {wv[2], 64'h0}; fwmask = {8'h3C, 8'h00};
    freq = 2'b10; fwe = 2'b10; bus.sha_fifo_gnt = 1'b1;
    expect_ev(EV_WR, wr_val(2'b10, 8'h3C, wv[2]), 0);
    step(1); idle_inputs();
    hproc = 2'b10; expect_ev(EV_PROC, 80'(0), 0);
    step(1); idle_inputs();
    bus.sha_hash_done = 1'b1; expect_ev(EV_DONE, 80'(2'b10), 1);
    step(1); idle_inputs();
    step(1);
    req = 2'b00;
    expect_ev(EV_GRANT, 80'(2'b00), 1); expect_ev(EV_EN, 80'(0), 1);
    step(3);

    check_eq("queue_drained", 80'(q.size()), 80'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
